uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the downstream consumer of the transmitter's serial line; recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) at 115200 baud from a 50 MHz clock.
- Runs in the same clk_50M domain as the transmitter. Used for loopback and for the host-to-FPGA command path.
- Presents each received byte on a parallel bus with a one-cycle valid strobe, and flags framing errors.

Parameters:
- CLKS_PER_BIT, 434, clocks per bit period (50 MHz / 115200, matches the transmitter).
- HALF_BIT, CLKS_PER_BIT/2 - 1 = 216, start-bit mid-point compare value.
- CNT_W, $clog2(CLKS_PER_BIT), bit-period counter width.

Ports:
- clk_50M  input  1  50 MHz system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  last good received byte; held until the next good frame.
- valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, clk_50M. rst_n is asynchronous and active-low, applied to all flops.
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, counter=0, bitpos=0, both sync flops=1.
- Input sync: rx passes through 2 flops to give rx_s. The FSM uses only rx_s.
- IDLE: counter=0, bitpos=0. If rx_s==0, go to START with counter=0.
- START: counter increments each cycle.
  - At counter==HALF_BIT, if rx_s==0, go to DATA with counter=0 and bitpos=0.
  - If rx_s==1 at that point, treat it as a glitch and return to IDLE; no valid, no frame_err.
- DATA: counter increments each cycle.
  - At counter==CLKS_PER_BIT-1: shift_reg[bitpos] <= rx_s and counter <= 0.
  - If bitpos==7, go to STOP; otherwise bitpos++.
  - Samples land at mid-bit, 217 clocks into each bit.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - If 1: data <= shift_reg, valid=1 for one cycle, go to IDLE.
  - If 0: frame_err=1 for one cycle, data unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one frame_err, not repeated frames.
- Latency: valid is high in the cycle after clock edge e0+4125, where e0 is the first edge at which the first sync flop captures rx=0.
- Back-to-back frames: after a valid stop sample, IDLE is re-entered about half a bit before the next start edge. Zero-gap streams from the transmitter are received without loss.
- valid and frame_err are mutually exclusive; neither is ever high for more than one cycle.
- No flow control: the next valid overwrites data. The consumer must capture data on valid.
- Reset mid-frame: the partial frame is discarded and the block returns to IDLE with all outputs at reset values. A low rx after reset release starts a new frame.
- Counter never exceeds CLKS_PER_BIT-1; bitpos never exceeds 7.

Decomposition:
- Package uart_pkg holds:
  - CLKS_PER_BIT and HALF_BIT, shared with the transmitter.
  - The state encoding: IDLE, START, DATA, STOP, BREAK as a 3-bit enum/localparams.
  - Frame constants DATA_BITS=8 and STOP_LEVEL=1.
- One sub-module: uart_sync2, a 2-flop synchronizer with reset value 1, reusable for any async input.

Test Plan:
- Single frame 8'hA5 at 434 clk/bit -> valid pulses exactly once, 4125 clocks after the first captured low; data=8'hA5; frame_err=0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap, from the transmitter in loopback -> three valid pulses, data in order 00, FF, 55; no frame_err.
- 100-clock low glitch on idle rx -> returns to IDLE after the start check; busy high for about 218 cycles; no valid, no frame_err.
- Frame 8'h3C with stop bit driven 0, then rx held low for 2000 clocks -> exactly one frame_err pulse; data retains its previous value; busy stays high until rx returns high.
- rst_n asserted at bit 4 of frame 8'hC3, released 10 clocks later while rx is idle -> all outputs at reset values; no valid; the next frame 8'h81 is received correctly.
- Baud tolerance: frame 8'h96 with bit period 424 and then 444 clocks -> data=8'h96 and valid in both runs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The bit timing is common to the transmitter and the receiver.
package uart_pkg;

    localparam int CLKS_PER_BIT = 434;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2 - 1;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam int   DATA_BITS  = 8;
    localparam int   BIT_W      = $clog2(DATA_BITS);
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so an idle-high line comes out of reset idle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge-aligned counter,
// one-cycle valid / frame_err strobes, and break absorption after a bad stop bit.
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        valid,
    output logic        frame_err,
    output logic        busy,
    output uart_state_e state_dbg
);

    // valid/frame_err are strobes with no ready: the consumer must take data in
    // the cycle valid is high, because the next good frame overwrites it.

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitpos_q <= '0;
            shift_q  <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitpos_q <= bitpos_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitpos_d = bitpos_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bitpos_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // A start bit that is gone by its mid-point was a glitch.
            START: begin
                if (cnt_q == CNT_W'(HALF_BIT)) begin
                    cnt_d    = '0;
                    bitpos_d = '0;
                    state_d  = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d            = '0;
                    shift_d[bitpos_q] = rx_s;
                    if (bitpos_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bitpos_d = bitpos_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s == STOP_LEVEL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Hold here while the line stays low so a break reports only once.
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven on rx, received bytes
// checked against an expected queue by a background monitor.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx      = 1'b1;
    logic [7:0]  data;
    logic        valid;
    logic        frame_err;
    logic        busy;
    uart_state_e state_dbg;

    uart_rx dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock and cycle counter
    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // scoreboard
    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int valid_seen = 0;
    int fe_seen = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver tasks (called on a falling edge)
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic stop_bit);
        start_cyc = cyc + 1;
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(b[i], n);
        drive_bit(stop_bit, n);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        repeat (2) @(negedge clk_50M);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_state"}, state_dbg, IDLE);
    endtask

    initial begin
        logic [7:0] b;
        int bcnt;

        fork
            forever begin
                @(negedge clk_50M);
                if (valid || frame_err) chk("valid_ferr_exclusive", valid && frame_err, 1'b0);
                if (valid) begin
                    valid_seen++;
                    last_valid_cyc = cyc;
                    chk("valid_one_cycle", prev_valid, 1'b0);
                    chk("valid_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        chk("rx_data", data, b);
                    end
                end
                if (frame_err) begin
                    fe_seen++;
                    chk("ferr_one_cycle", prev_ferr, 1'b0);
                end
                prev_valid = valid;
                prev_ferr  = frame_err;
            end
        join_none

        // reset
        repeat (5) @(negedge clk_50M);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50M);

        // single frame and latency
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, CLKS_PER_BIT, 1'b1);
        rx = 1'b1;
        wait_drain(1000);
        chk("a5_latency", last_valid_cyc - start_cyc, 4125);
        chk("a5_valid_count", valid_seen, 1);
        chk("a5_no_ferr", fe_seen, 0);

        // back-to-back frames, no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, CLKS_PER_BIT, 1'b1);
        send_frame(8'hFF, CLKS_PER_BIT, 1'b1);
        send_frame(8'h55, CLKS_PER_BIT, 1'b1);
        rx = 1'b1;
        wait_drain(1000);
        chk("b2b_valid_count", valid_seen, 4);
        chk("b2b_no_ferr", fe_seen, 0);

        // 100-clock glitch
        bcnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 100) rx = 1'b1;
            @(negedge clk_50M);
            if (busy) bcnt++;
        end
        chk("glitch_busy_len", (bcnt >= 214 && bcnt <= 220), 1'b1);
        chk("glitch_state", state_dbg, IDLE);
        chk("glitch_no_valid", valid_seen, 4);
        chk("glitch_no_ferr", fe_seen, 0);

        // bad stop bit followed by a held-low line
        send_frame(8'h3C, CLKS_PER_BIT, 1'b0);
        drive_bit(1'b0, 2000);
        chk("break_busy", busy, 1'b1);
        chk("break_state", state_dbg, BREAK);
        chk("break_one_ferr", fe_seen, 1);
        chk("break_data_held", data, 8'h55);
        rx = 1'b1;
        repeat (10) @(negedge clk_50M);
        chk("break_release_idle", busy, 1'b0);
        chk("break_ferr_after", fe_seen, 1);
        chk("break_no_valid", valid_seen, 4);

        // reset in the middle of a frame
        b = 8'hC3;
        drive_bit(1'b0, CLKS_PER_BIT);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CLKS_PER_BIT);
        drive_bit(b[4], 100);
        chk("midframe_busy", busy, 1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (10) @(negedge clk_50M);
        check_reset_values("midreset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50M);
        chk("midreset_no_valid", valid_seen, 4);
        exp_q.push_back(8'h81);
        send_frame(8'h81, CLKS_PER_BIT, 1'b1);
        rx = 1'b1;
        wait_drain(1000);
        chk("after_reset_valid_count", valid_seen, 5);

        // baud tolerance
        exp_q.push_back(8'h96);
        send_frame(8'h96, 424, 1'b1);
        rx = 1'b1;
        wait_drain(1000);
        chk("fast_baud_data", data, 8'h96);
        repeat (20) @(negedge clk_50M);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 444, 1'b1);
        rx = 1'b1;
        wait_drain(1000);
        chk("slow_baud_data", data, 8'h96);
        chk("final_valid_count", valid_seen, 7);
        chk("final_ferr_count", fe_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
